// File: rtl/ifu_fetch.sv
// Instruction fetch unit.
// Latches the PC, issues one single-beat read to memory, and hands the returned
// word to decode. Only one request is ever outstanding. A flush throws away
// whatever fetch is in progress so the next fetch starts from the redirected PC.
//
// Handshake rule on every valid/ready pair (mem_req, mem_rsp, inst): a transfer
// happens in a cycle where valid and ready are both high. Once valid is raised
// it stays high, with its payload stable, until that transfer. The one exception
// is inst_valid, which drops without a transfer when flush is asserted.
module ifu_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_w_en,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [INST_W-1:0]   inst_q;
    logic                err_q;
    logic                drop_q;
    logic [CNT_W-1:0]    stall_q;

    // Control strobes produced by the next-state logic.
    logic                load_addr;
    logic                load_inst;
    logic                drop_set;
    logic                drop_clr;
    logic                stalling;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_n       = state_q;
        load_addr     = 1'b0;
        load_inst     = 1'b0;
        drop_set      = 1'b0;
        drop_clr      = 1'b0;
        stalling      = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        inst_valid    = 1'b0;
        pc_w_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // During a flush the PC is being rewritten; sample it next cycle.
                if (!flush) begin
                    load_addr = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                stalling      = 1'b1;
                if (mem_req_ready) begin
                    // The request cannot be recalled, so a flushed fetch still
                    // issues and its response is swallowed in DROP.
                    drop_clr = 1'b1;
                    state_n  = (flush || drop_q) ? S_DROP : S_WAIT;
                end else if (flush) begin
                    drop_set = 1'b1;
                end
            end
            S_WAIT: begin
                mem_rsp_ready = 1'b1;
                stalling      = 1'b1;
                if (flush) begin
                    state_n = mem_rsp_valid ? S_IDLE : S_DROP;
                end else if (mem_rsp_valid) begin
                    load_inst = 1'b1;
                    state_n   = S_OUT;
                end
            end
            S_DROP: begin
                mem_rsp_ready = 1'b1;
                stalling      = 1'b1;
                drop_clr      = 1'b1;
                if (mem_rsp_valid) begin
                    state_n = S_IDLE;
                end
            end
            S_OUT: begin
                inst_valid = 1'b1;
                // Flush wins over acceptance: the instruction is abandoned and
                // the PC is left for the redirect to overwrite.
                pc_w_en    = inst_ready && !flush;
                if (flush || inst_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Fetch address, captured once per fetch and held for request and decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (load_addr) begin
            addr_q <= pc;
        end
    end

    // Returned instruction and fault flag; a faulted fetch presents a zero word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q <= '0;
            err_q  <= 1'b0;
        end else if (load_inst) begin
            inst_q <= mem_rsp_err ? '0 : mem_rsp_data;
            err_q  <= mem_rsp_err;
        end
    end

    // Remembers a flush seen while the request was still waiting for acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 1'b0;
        end else if (drop_clr) begin
            drop_q <= 1'b0;
        end else if (drop_set) begin
            drop_q <= 1'b1;
        end
    end

    // Free-running count of cycles spent waiting on memory; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stalling) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign mem_req_addr = addr_q;
    assign inst         = inst_q;
    assign inst_pc      = addr_q;
    assign inst_err     = err_q;
    assign stall_cnt    = stall_q;
    assign state_dbg    = state_q;

endmodule
